// File: rtl/lab3_cache_arb_pkg.sv
// Shared types for the cache-complex memory arbiter: 4-byte memory messages,
// default sizing, and a helper that sizes port-id fields.
package lab3_cache_arb_pkg;

    localparam int DEFAULT_NUM_PORTS       = 2;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    typedef enum logic [2:0] {
        MEM_READ  = 3'd0,
        MEM_WRITE = 3'd1,
        MEM_INIT  = 3'd2
    } mem_type_t;

    typedef struct packed {
        mem_type_t   typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        mem_type_t   typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Port-id field width; a single bit minimum keeps degenerate sizes legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lab3_cache_arb_route_queue.sv
// Circular FIFO of port ids recording which port owns each in-flight memory request.
// Head is visible combinationally; enqueue is dropped when full, dequeue ignored when empty.
module lab3_cache_arb_route_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enq_val_i,
    input  logic [ID_W-1:0] enq_id_i,
    input  logic            deq_i,
    output logic [ID_W-1:0] head_id_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq, do_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_enq    = enq_val_i && !full_o;
    assign do_deq    = deq_i && !empty_o;
    assign head_id_o = entry_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is never observed while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            entry_q[wr_ptr_q] <= enq_id_i;
        end
    end

endmodule

// File: rtl/lab3_cache_mem_arbiter.sv
// Round-robin merge of cache request streams onto one memory port, in-order response return,
// and sticky flush_done aggregation; zero added latency, stalls when the route queue is full.
module lab3_cache_mem_arbiter
    import lab3_cache_arb_pkg::*;
#(
    parameter int NUM_PORTS       = DEFAULT_NUM_PORTS,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_PORTS-1:0] cache_req_val_i,
    output logic [NUM_PORTS-1:0] cache_req_rdy_o,
    input  mem_req_4B_t          cache_req_msg_i [NUM_PORTS],
    output logic [NUM_PORTS-1:0] cache_resp_val_o,
    input  logic [NUM_PORTS-1:0] cache_resp_rdy_i,
    output mem_resp_4B_t         cache_resp_msg_o [NUM_PORTS],
    output logic                 mem_req_val_o,
    input  logic                 mem_req_rdy_i,
    output mem_req_4B_t          mem_req_msg_o,
    input  logic                 mem_resp_val_i,
    output logic                 mem_resp_rdy_o,
    input  mem_resp_4B_t         mem_resp_msg_i,
    input  logic                 flush_i,
    input  logic [NUM_PORTS-1:0] flush_done_in_i,
    output logic                 flush_done_o
);

    localparam int ID_W = id_width(NUM_PORTS);
    typedef logic [ID_W-1:0] port_id_t;

    port_id_t             rr_ptr_q, rr_ptr_d;
    port_id_t             grant_id, cand, head_id;
    logic                 found;
    logic                 full, empty;
    logic                 in_reset;
    logic                 req_fire, resp_fire;
    logic [NUM_PORTS-1:0] done_q, done_d;

    function automatic port_id_t next_id(input port_id_t id);
        return (id == port_id_t'(NUM_PORTS - 1)) ? '0 : id + port_id_t'(1);
    endfunction

    // Outputs are forced idle for the whole time reset is held, not just after the edge.
    assign in_reset = !reset_i;

    always_comb begin
        grant_id = rr_ptr_q;
        found    = 1'b0;
        cand     = rr_ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && cache_req_val_i[cand]) begin
                grant_id = cand;
                found    = 1'b1;
            end
            cand = next_id(cand);
        end
    end

    assign mem_req_val_o = (|cache_req_val_i) && !full && !in_reset;
    assign mem_req_msg_o = cache_req_msg_i[grant_id];
    assign req_fire      = mem_req_val_o && mem_req_rdy_i;
    assign rr_ptr_d      = req_fire ? next_id(grant_id) : rr_ptr_q;

    always_comb begin
        cache_req_rdy_o  = '0;
        cache_resp_val_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cache_req_rdy_o[i]  = (port_id_t'(i) == grant_id) && mem_req_rdy_i && !full && !in_reset;
            cache_resp_val_o[i] = mem_resp_val_i && !empty && (port_id_t'(i) == head_id);
            cache_resp_msg_o[i] = mem_resp_msg_i;
        end
    end

    assign mem_resp_rdy_o = !empty && cache_resp_rdy_i[head_id];
    assign resp_fire      = mem_resp_val_i && mem_resp_rdy_o;

    lab3_cache_arb_route_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_route_queue (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enq_val_i (req_fire),
        .enq_id_i  (grant_id),
        .deq_i     (resp_fire),
        .head_id_o (head_id),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Caches keep writing back through the arbiter while flush is high.
    assign done_d       = flush_i ? (done_q | flush_done_in_i) : '0;
    assign flush_done_o = flush_i && (&done_q);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_ptr_q <= '0;
            done_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Scenario bench for lab3_cache_mem_arbiter with a request/response scoreboard
// and a simple in-order memory model.
module tb_lab3_cache_mem_arbiter;
    import lab3_cache_arb_pkg::*;

    localparam int NP = 2;
    localparam int MO = 4;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b1;
    logic [NP-1:0] cache_req_val, cache_req_rdy, cache_resp_val, cache_resp_rdy, flush_done_in;
    mem_req_4B_t   cache_req_msg [NP];
    mem_resp_4B_t  cache_resp_msg [NP];
    logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy, flush, flush_done;
    mem_req_4B_t   mem_req_msg;
    mem_resp_4B_t  mem_resp_msg;

    typedef struct {
        int          port;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] mem_q [$];
    int          errors = 0;
    int          checks = 0;

    lab3_cache_mem_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .cache_req_val_i  (cache_req_val),
        .cache_req_rdy_o  (cache_req_rdy),
        .cache_req_msg_i  (cache_req_msg),
        .cache_resp_val_o (cache_resp_val),
        .cache_resp_rdy_i (cache_resp_rdy),
        .cache_resp_msg_o (cache_resp_msg),
        .mem_req_val_o    (mem_req_val),
        .mem_req_rdy_i    (mem_req_rdy),
        .mem_req_msg_o    (mem_req_msg),
        .mem_resp_val_i   (mem_resp_val),
        .mem_resp_rdy_o   (mem_resp_rdy),
        .mem_resp_msg_i   (mem_resp_msg),
        .flush_i          (flush),
        .flush_done_in_i  (flush_done_in),
        .flush_done_o     (flush_done)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic mem_req_4B_t mk_req(input logic [31:0] addr);
        mem_req_4B_t r;
        r        = '0;
        r.typ    = MEM_READ;
        r.addr   = addr;
        r.opaque = addr[9:2];
        return r;
    endfunction

    function automatic logic [31:0] rdata(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle();
        cache_req_val  = '0;
        cache_resp_rdy = '1;
        mem_req_rdy    = 1'b1;
        mem_resp_val   = 1'b0;
        mem_resp_msg   = '0;
        flush          = 1'b0;
        flush_done_in  = '0;
        for (int i = 0; i < NP; i++) cache_req_msg[i] = mk_req(32'h0);
    endtask

    task automatic note_fire(input int port, input logic [31:0] addr);
        sb_q.push_back('{port, rdata(addr)});
        mem_q.push_back(addr);
    endtask

    task automatic mem_drive();
        mem_resp_val = 1'b1;
        mem_resp_msg = '0;
        if (mem_q.size() != 0) mem_resp_msg.data = rdata(mem_q[0]);
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        reset_i = 1'b0;
        next_cycle();
        next_cycle();
        reset_i = 1'b1;
        sb_q.delete();
        mem_q.delete();
    endtask

    task automatic test_reset();
        reset_i       = 1'b0;
        idle();
        cache_req_val = '1;
        mem_resp_val  = 1'b1;
        flush         = 1'b1;
        flush_done_in = '1;
        next_cycle();
        mid();
        checks++;
        if (mem_req_val !== 1'b0) begin errors++; $display("FAIL reset_mem_req_val got=%b exp=0", mem_req_val); end
        checks++;
        if (cache_req_rdy !== '0) begin errors++; $display("FAIL reset_cache_req_rdy got=%b exp=00", cache_req_rdy); end
        checks++;
        if (cache_resp_val !== '0) begin errors++; $display("FAIL reset_cache_resp_val got=%b exp=00", cache_resp_val); end
        checks++;
        if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_mem_resp_rdy got=%b exp=0", mem_resp_rdy); end
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        next_cycle();
        idle();
        reset_i = 1'b1;
        mid();
    endtask

    task automatic test_single();
        sb_t e;
        logic [31:0] d;
        next_cycle();
        idle();
        cache_req_val    = 2'b01;
        cache_req_msg[0] = mk_req(32'h1000);
        cache_req_msg[1] = mk_req(32'h3000);
        mid();
        checks++;
        if (mem_req_msg !== mk_req(32'h1000)) begin errors++; $display("FAIL single_req_msg got=%h exp=%h", mem_req_msg, mk_req(32'h1000)); end
        checks++;
        if ({mem_req_val, cache_req_rdy} !== 3'b101) begin errors++; $display("FAIL single_req_handshake got=%b exp=101", {mem_req_val, cache_req_rdy}); end
        note_fire(0, 32'h1000);
        next_cycle();
        cache_req_val = '0;
        mem_drive();
        mid();
        checks++;
        if (cache_resp_val !== 2'b01) begin errors++; $display("FAIL single_resp_val got=%b exp=01", cache_resp_val); end
        checks++;
        if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL single_mem_resp_rdy got=%b exp=1", mem_resp_rdy); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            d = mem_q.pop_front();
            checks++;
            if (cache_resp_msg[0].data !== e.data) begin errors++; $display("FAIL single_resp_data got=%h exp=%h", cache_resp_msg[0].data, e.data); end
        end
        next_cycle();
        mem_resp_val = 1'b0;
        mid();
        checks++;
        if (cache_resp_val !== 2'b00) begin errors++; $display("FAIL single_resp_idle got=%b exp=00", cache_resp_val); end
    endtask

    task automatic test_rr();
        sb_t e;
        logic [31:0] d, a;
        int p;
        do_reset();
        cache_req_val = '1;
        for (int k = 0; k < 4; k++) begin
            cache_req_msg[0] = mk_req(32'h100 + k * 16);
            cache_req_msg[1] = mk_req(32'h200 + k * 16);
            mid();
            p = k % 2;
            a = (p == 0) ? 32'h100 + k * 16 : 32'h200 + k * 16;
            checks++;
            if (cache_req_rdy !== oh(p)) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, cache_req_rdy, oh(p)); end
            checks++;
            if (mem_req_msg.addr !== a) begin errors++; $display("FAIL rr_msg%0d got=%h exp=%h", k, mem_req_msg.addr, a); end
            note_fire(p, a);
            next_cycle();
        end
        cache_req_val = '0;
        for (int k = 0; k < 4; k++) begin
            mem_drive();
            mid();
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                d = mem_q.pop_front();
                checks++;
                if (cache_resp_val !== oh(e.port)) begin errors++; $display("FAIL rr_resp_port%0d got=%b exp=%b", k, cache_resp_val, oh(e.port)); end
                checks++;
                if (cache_resp_msg[e.port].data !== e.data) begin errors++; $display("FAIL rr_resp_data%0d got=%h exp=%h", k, cache_resp_msg[e.port].data, e.data); end
            end
            next_cycle();
        end
        mem_resp_val = 1'b0;
    endtask

    task automatic test_full();
        sb_t e;
        logic [31:0] d, a;
        do_reset();
        cache_req_val = 2'b01;
        a = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            cache_req_msg[0] = mk_req(a);
            mid();
            checks++;
            if (k < 4) begin
                if ({mem_req_val, cache_req_rdy} !== 3'b101) begin errors++; $display("FAIL full_accept%0d got=%b exp=101", k, {mem_req_val, cache_req_rdy}); end
                note_fire(0, a);
                a = a + 4;
            end else begin
                if ({mem_req_val, cache_req_rdy} !== 3'b000) begin errors++; $display("FAIL full_block%0d got=%b exp=000", k, {mem_req_val, cache_req_rdy}); end
            end
            next_cycle();
        end
        mem_drive();
        mid();
        checks++;
        if (mem_req_val !== 1'b0) begin errors++; $display("FAIL full_same_cycle_deq got=%b exp=0", mem_req_val); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            d = mem_q.pop_front();
            checks++;
            if (cache_resp_msg[0].data !== e.data || cache_resp_val !== 2'b01) begin
                errors++; $display("FAIL full_first_resp got=%b/%h exp=01/%h", cache_resp_val, cache_resp_msg[0].data, e.data);
            end
        end
        next_cycle();
        mem_resp_val = 1'b0;
        mid();
        checks++;
        if ({mem_req_val, cache_req_rdy} !== 3'b101) begin errors++; $display("FAIL full_reopen got=%b exp=101", {mem_req_val, cache_req_rdy}); end
        note_fire(0, a);
        next_cycle();
        cache_req_val = '0;
        for (int k = 0; k < 4; k++) begin
            mem_drive();
            mid();
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                d = mem_q.pop_front();
                checks++;
                if (cache_resp_msg[0].data !== e.data) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", k, cache_resp_msg[0].data, e.data); end
            end
            next_cycle();
        end
        mem_resp_val = 1'b0;
    endtask

    task automatic test_resp_stall();
        sb_t e;
        logic [31:0] d, a;
        int pseq [3] = '{1, 0, 1};
        logic [NP-1:0] exp_val [5] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        logic          exp_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'h3000 + k * 4;
            cache_req_val           = oh(pseq[k]);
            cache_req_msg[pseq[k]]  = mk_req(a);
            mid();
            checks++;
            if (cache_req_rdy !== oh(pseq[k])) begin errors++; $display("FAIL stall_grant%0d got=%b exp=%b", k, cache_req_rdy, oh(pseq[k])); end
            note_fire(pseq[k], a);
            next_cycle();
        end
        cache_req_val  = '0;
        cache_resp_rdy = 2'b10;
        for (int r = 0; r < 5; r++) begin
            if (r == 3) cache_resp_rdy = 2'b11;
            mem_drive();
            mid();
            checks++;
            if (cache_resp_val !== exp_val[r]) begin errors++; $display("FAIL stall_resp_val%0d got=%b exp=%b", r, cache_resp_val, exp_val[r]); end
            checks++;
            if (mem_resp_rdy !== exp_rdy[r]) begin errors++; $display("FAIL stall_mem_resp_rdy%0d got=%b exp=%b", r, mem_resp_rdy, exp_rdy[r]); end
            if (mem_resp_rdy === 1'b1 && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                d = mem_q.pop_front();
                checks++;
                if (cache_resp_val !== oh(e.port) || cache_resp_msg[e.port].data !== e.data) begin
                    errors++; $display("FAIL stall_order%0d got=%b/%h exp=%b/%h", r, cache_resp_val, cache_resp_msg[e.port].data, oh(e.port), e.data);
                end
            end
            next_cycle();
        end
        mem_resp_val = 1'b0;
        mid();
        checks++;
        if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL stall_empty_rdy got=%b exp=0", mem_resp_rdy); end
    endtask

    task automatic test_flush();
        logic e;
        next_cycle();
        idle();
        flush = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            flush_done_in = '0;
            cache_req_val = '0;
            mem_req_rdy   = 1'b1;
            if (t == 3) flush_done_in = 2'b10;
            if (t == 7) flush_done_in = 2'b01;
            if (t == 11) flush = 1'b0;
            if (t == 5) begin
                cache_req_val    = 2'b01;
                cache_req_msg[0] = mk_req(32'h4000);
                mem_req_rdy      = 1'b0;
            end
            mid();
            e = (t >= 8 && t <= 10);
            checks++;
            if (flush_done !== e) begin errors++; $display("FAIL flush_done_t%0d got=%b exp=%b", t, flush_done, e); end
            if (t == 5) begin
                checks++;
                if (mem_req_val !== 1'b1) begin errors++; $display("FAIL flush_arb_active got=%b exp=1", mem_req_val); end
            end
            next_cycle();
        end
        cache_req_val = '0;
        mem_req_rdy   = 1'b1;
        flush         = 1'b1;
        flush_done_in = '0;
        mid();
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_sticky_cleared got=%b exp=0", flush_done); end
        next_cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        idle();
        cache_req_val = 2'b01;
        for (int k = 0; k < 2; k++) begin
            cache_req_msg[0] = mk_req(32'h5000 + k * 4);
            mid();
            checks++;
            if (cache_req_rdy !== 2'b01) begin errors++; $display("FAIL rmid_pre_grant%0d got=%b exp=01", k, cache_req_rdy); end
            note_fire(0, 32'h5000 + k * 4);
            next_cycle();
        end
        reset_i          = 1'b0;
        cache_req_val    = '1;
        cache_req_msg[0] = mk_req(32'h6000);
        cache_req_msg[1] = mk_req(32'h7000);
        mem_drive();
        #1;
        checks++;
        if ({mem_req_val, cache_req_rdy, cache_resp_val, mem_resp_rdy} !== 6'b0) begin
            errors++; $display("FAIL rmid_async_idle got=%b exp=000000", {mem_req_val, cache_req_rdy, cache_resp_val, mem_resp_rdy});
        end
        sb_q.delete();
        mem_q.delete();
        next_cycle();
        reset_i     = 1'b1;
        mem_req_rdy = 1'b0;
        mid();
        checks++;
        if ({mem_resp_rdy, cache_resp_val} !== 3'b000) begin errors++; $display("FAIL rmid_queue_empty got=%b exp=000", {mem_resp_rdy, cache_resp_val}); end
        checks++;
        if (mem_req_val !== 1'b1 || mem_req_msg.addr !== 32'h6000) begin
            errors++; $display("FAIL rmid_rr_ptr_zero got=%b/%h exp=1/00006000", mem_req_val, mem_req_msg.addr);
        end
        next_cycle();
        idle();
        mid();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_single();
        test_rr();
        test_full();
        test_resp_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
